// File: rtl/ahb_master_pkg.sv
// rtl/ahb_master_pkg.sv - shared AHB-lite master transfer types and constants
package ahb_master_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_t;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } mstate_t;

endpackage

// File: rtl/ahb_wait_timer.sv
// rtl/ahb_wait_timer.sv - saturating data-phase wait-state counter with expiry pulse
module ahb_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic tick,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (tick && cnt != CW'(LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires on the wait cycle whose edge brings the count to LIMIT.
   assign expired = en && tick && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ahb_lite_master_cmd.sv
// rtl/ahb_lite_master_cmd.sv - command stream to single-word AHB-lite master; AHB_MASTER_TIMEOUT_EN adds a wait limit
module ahb_lite_master_cmd
   import ahb_master_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [DATA_W-1:0] HWDATA,
   output logic              HSEL,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP,
   output logic              busy
);
   mstate_t           state;
   logic [DATA_W-1:0] wdata_q;
   logic              timeout_hit;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign HSIZE     = HSIZE_WORD;

`ifdef AHB_MASTER_TIMEOUT_EN
   ahb_wait_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (HCLK),
      .rst    (HRESET),
      .en     (state == S_DATA),
      .tick   (!HREADY),
      .expired(timeout_hit)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= S_IDLE;
         HTRANS    <= TR_IDLE;
         HSEL      <= 1'b0;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  // Misaligned words never reach the bus.
                  if (cmd_addr[1:0] != 2'b00) begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     HTRANS  <= TR_NONSEQ;
                     HSEL    <= 1'b1;
                     HADDR   <= cmd_addr;
                     HWRITE  <= cmd_write;
                     wdata_q <= cmd_wdata;
                     state   <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (HREADY) begin
                  HTRANS <= TR_IDLE;
                  HSEL   <= 1'b0;
                  HWDATA <= HWRITE ? wdata_q : '0;
                  state  <= S_DATA;
               end
            end
            S_DATA: begin
               // The first ERROR cycle arrives with HREADY low and is skipped.
               if (HREADY) begin
                  rsp_err   <= HRESP[0];
                  rsp_rdata <= (!HWRITE && HRESP == HRESP_OKAY) ? HRDATA : '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (timeout_hit) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
